// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter.
// m0 = CPU data port, m1 = CPU instruction port. Arbitration is registered:
// a request seen in IDLE gets the slave on the next cycle. The owner keeps the
// slave for as long as its cyc stays high. A watchdog forces termination when
// the slave stalls a strobe for too long.
module wb_arbiter_2m #(
   parameter bit          FAIR           = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_data_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   output logic [31:0] m0_data_o,
   output logic        m0_ack_o,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_data_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   output logic [31:0] m1_data_o,
   output logic        m1_ack_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_data_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic [31:0] s_data_i,
   input  logic        s_ack_i,
   output logic [1:0]  gnt_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1, S_TOUT} state_t;

   // Last cycle of the stall window: a stall seen here ends the transfer.
   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        last_gnt_q, last_gnt_d;   // 0 = m0 owned last, 1 = m1
   logic [15:0] cnt_q, cnt_d;

   logic own_cyc, own_stb, stall;

   // cyc/stb of the current owner; only meaningful in GNT0/GNT1
   assign own_cyc = (state_q == S_GNT1) ? m1_cyc_i : m0_cyc_i;
   assign own_stb = (state_q == S_GNT1) ? m1_stb_i : m0_stb_i;
   assign stall   = own_stb & ~s_ack_i;

   // State, last-grant and watchdog registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         last_gnt_q <= 1'b1;              // m1 "owned last", so m0 wins first
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next state: arbitrate in IDLE, hold while the owner keeps cyc, watchdog
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      cnt_d      = '0;
      case (state_q)
         S_IDLE: begin
            // m0 wins unless m1 also asks and fairness says it is m1's turn
            if (m0_cyc_i && (!m1_cyc_i || !FAIR || last_gnt_q)) begin
               state_d    = S_GNT0;
               last_gnt_d = 1'b0;
            end else if (m1_cyc_i) begin
               state_d    = S_GNT1;
               last_gnt_d = 1'b1;
            end
         end
         S_GNT0, S_GNT1: begin
            // Dropping cyc always releases the slave, even mid-stall
            if (!own_cyc)
               state_d = S_IDLE;
            else if (stall) begin
               if (cnt_q == LIMIT)
                  state_d = S_TOUT;
               else
                  cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;      // S_TOUT lasts exactly one cycle
      endcase
   end

   // Outputs: routed from the owner in GNTx, fake ack in TOUT, quiet otherwise
   always_comb begin
      s_addr_o  = '0;
      s_data_o  = '0;
      s_we_o    = 1'b0;
      s_sel_o   = '0;
      s_stb_o   = 1'b0;
      s_cyc_o   = 1'b0;
      m0_data_o = '0;
      m0_ack_o  = 1'b0;
      m1_data_o = '0;
      m1_ack_o  = 1'b0;
      gnt_o     = 2'b00;
      timeout_o = 1'b0;
      case (state_q)
         S_GNT0: begin
            s_addr_o  = m0_addr_i;
            s_data_o  = m0_data_i;
            s_we_o    = m0_we_i;
            s_sel_o   = m0_sel_i;
            s_stb_o   = m0_stb_i;
            s_cyc_o   = m0_cyc_i;
            m0_data_o = s_data_i;
            m0_ack_o  = s_ack_i;
            gnt_o     = 2'b01;
         end
         S_GNT1: begin
            s_addr_o  = m1_addr_i;
            s_data_o  = m1_data_i;
            s_we_o    = m1_we_i;
            s_sel_o   = m1_sel_i;
            s_stb_o   = m1_stb_i;
            s_cyc_o   = m1_cyc_i;
            m1_data_o = s_data_i;
            m1_ack_o  = s_ack_i;
            gnt_o     = 2'b10;
         end
         S_TOUT: begin
            // last_gnt still names the master whose strobe timed out
            timeout_o = 1'b1;
            if (last_gnt_q) begin
               m1_ack_o  = 1'b1;
               m1_data_o = TIMEOUT_DATA;
            end else begin
               m0_ack_o  = 1'b1;
               m0_data_o = TIMEOUT_DATA;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter.
- Lets the CPU's data bus port (m0) and instruction bus port (m1) share a single external Wishbone slave port (RAM/flash/peripheral bridge).
- Sits between the CPU's two bus-interface units and the SoC interconnect.
- Provides registered grant, cycle-locked ownership, optional fairness, and a bus-timeout watchdog that prevents a dead slave from hanging the pipeline.

Parameters:
- FAIR, 1: 1 = alternate grant when both masters request in IDLE; 0 = m0 (data) strict priority.
- TIMEOUT_CYCLES, 256: cycles a granted strobe may wait for s_ack before forced termination; legal range 2..65535.
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned to the master on a forced termination.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- m0_addr_i, m0_data_i  in  32 each  data master address / write data
- m0_we_i  in  1  data master write enable
- m0_sel_i  in  4  data master byte select
- m0_stb_i, m0_cyc_i  in  1 each  data master strobe / cycle
- m0_data_o  out  32  read data to data master
- m0_ack_o  out  1  ack to data master
- m1_addr_i, m1_data_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i  in  32/32/1/4/1/1  instruction master, same meanings as m0
- m1_data_o  out  32  read data to instruction master
- m1_ack_o  out  1  ack to instruction master
- s_addr_o, s_data_o  out  32 each  slave address / write data
- s_we_o  out  1  slave write enable
- s_sel_o  out  4  slave byte select
- s_stb_o, s_cyc_o  out  1 each  slave strobe / cycle
- s_data_i  in  32  slave read data
- s_ack_i  in  1  slave ack
- gnt_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 in IDLE/TOUT
- timeout_o  out  1  one-cycle pulse on forced termination

Behaviour:
- Reset: rst low asynchronously forces state IDLE, last_gnt=1 (so m0 wins first), counter=0. All outputs 0: s_*, m*_ack_o, m*_data_o, gnt_o, timeout_o.
- Reset mid-transfer: all outputs drop in the same instant, with no ack to any master.
- States: IDLE, GNT0, GNT1, TOUT.
- IDLE, outputs: all s_* = 0, all acks = 0.
- IDLE, next state:
  - only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1.
  - both asserted: FAIR=0 -> GNT0; FAIR=1 -> grant the master not in last_gnt.
  - neither -> stay IDLE.
  - Arbitration latency: 1 cycle from cyc to s_cyc_o.
- GNTx, slave side: s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o are combinational from master x.
- GNTx, master side:
  - mx_ack_o = s_ack_i; mx_data_o = s_data_i.
  - Non-granted master sees ack=0, data=0; its stb is ignored.
  - gnt_o one-hot for x; last_gnt updates to x on entry.
- GNTx exit:
  - Ownership is held while mx_cyc_i=1, so multi-beat/back-to-back strobes stay locked.
  - mx_cyc_i=0 -> IDLE next cycle, giving one dead cycle between owners.
- Watchdog counter (16 bit):
  - Increments each GNTx cycle with s_stb_o=1 and s_ack_i=0.
  - Clears on s_ack_i=1, on s_stb_o=0, and in IDLE/TOUT.
  - Counter == TIMEOUT_CYCLES-1 with no ack in that cycle -> TOUT next cycle.
  - s_ack_i arriving in the limit cycle: real ack wins, no timeout.
- TOUT (exactly 1 cycle):
  - s_cyc_o = s_stb_o = 0.
  - Offending master gets ack=1 and data=TIMEOUT_DATA.
  - timeout_o=1, gnt_o=00.
  - Next state IDLE; arbitration then restarts normally.
- Late slave ack arriving in IDLE/TOUT is discarded; it is never forwarded.
- A master dropping cyc while stb is pending, without an ack, is legal: return to IDLE and clear the counter.

Test Plan:
- Reset/single read: rst=0 then 1; m1 read @0x1FC0_0000, slave acks after 3 cycles with 0x2402_0001 -> s_cyc_o 1 cycle after m1_cyc_i; gnt_o=10; m1_ack_o=1 with m1_data_o=0x2402_0001; m0_ack_o=0 throughout.
- Simultaneous request, FAIR=1: m0 and m1 assert cyc in the same cycle out of reset -> m0 granted first (gnt_o=01); after m0 drops cyc, 1 IDLE cycle, then gnt_o=10. Repeat with FAIR=0 and m0 re-requesting -> m0 wins twice.
- Locked burst: m0 holds cyc for 4 write strobes (addr 0x8000_0000..0x8000_000C, sel=4'b1111) while m1 requests -> all 4 writes reach the slave, m1 ungranted until m0 drops cyc.
- Timeout: TIMEOUT_CYCLES=8, slave never acks m1 read -> after 8 strobe cycles: one-cycle TOUT, m1_ack_o=1, m1_data_o=0xDEADBEEF, timeout_o pulse, s_cyc_o=0; then IDLE.
- Ack at limit: TIMEOUT_CYCLES=8, slave acks on 8th cycle -> normal ack, timeout_o stays 0.
- Async reset mid-transfer: rst low during GNT0 with stb pending -> s_cyc_o, gnt_o, acks go 0 immediately, before any clk edge; after release, the first request is served normally.
